// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory-access sequencer: FSM state codes, ALU function
// selects and the control-word layout consumed by the RAM datapath.
package mem_access_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_LD_RD = 3'd2;
  localparam logic [2:0] S_LD_WB = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // ALU function-select codes; these must track the ALU's own decoder.
  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_OR   = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_SUB  = 5'b01001;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_NOT  = 5'b10000;
  localparam logic [4:0] FS_SHL  = 5'b10100;
  localparam logic [4:0] FS_SHR  = 5'b11000;

  typedef struct packed {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic [63:0] k;
    logic        k_sel;
    logic        c0;
    logic        w;
    logic        en_b;
    logic        en_alu;
    logic        en_addr;
    logic        cs;
    logic        we;
    logic        oe;
  } ctrl_word_t;

endpackage

// File: rtl/mem_ctrl_word_gen.sv
// Combinational decode of the sequencer state and latched request fields into
// the datapath control word. IDLE and FIN drive an all-zero word.
module mem_ctrl_word_gen
  import mem_access_ctrl_pkg::*;
#(
  parameter int         LEN_W  = 3,
  parameter logic [4:0] FS_SEL = FS_ADD
) (
  input  logic [2:0]       state_i,
  input  logic [4:0]       rn_i,
  input  logic [4:0]       rt_i,
  input  logic [63:0]      imm_i,
  input  logic [LEN_W-1:0] idx_i,
  output ctrl_word_t       cw_o
);

  logic [4:0]  reg_idx;
  logic [63:0] k_addr;

  // Register index wraps mod 32; address offset wraps mod 2^64.
  assign reg_idx = rt_i + 5'(idx_i);
  assign k_addr  = imm_i + (64'(idx_i) << 3);

  always_comb begin
    cw_o = '0;
    if (state_i == S_ST || state_i == S_LD_RD || state_i == S_LD_WB) begin
      cw_o.sa      = rn_i;
      cw_o.fs      = FS_SEL;
      cw_o.k       = k_addr;
      cw_o.k_sel   = 1'b1;
      cw_o.en_addr = 1'b1;
      cw_o.cs      = 1'b1;
    end
    case (state_i)
      S_ST: begin
        cw_o.sb   = reg_idx;
        cw_o.en_b = 1'b1;
        cw_o.we   = 1'b1;
      end
      S_LD_RD: begin
        cw_o.da = reg_idx;
        cw_o.oe = 1'b1;
      end
      S_LD_WB: begin
        cw_o.da = reg_idx;
        cw_o.oe = 1'b1;
        cw_o.w  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer for LDUR/STUR-style single and burst accesses; owns the FSM, word
// index and latched request, and drives the datapath control inputs directly.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int         MAX_LEN = 4,
  parameter int         LEN_W   = 3,
  parameter logic [4:0] FS_ADD  = 5'b01000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [4:0]       req_rn,
  input  logic [4:0]       req_rt,
  input  logic [63:0]      req_imm,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic             done,
  output logic [4:0]       SA,
  output logic [4:0]       SB,
  output logic [4:0]       DA,
  output logic [4:0]       FS,
  output logic [63:0]      K,
  output logic             K_SEL,
  output logic             C0,
  output logic             W,
  output logic             EN_B,
  output logic             EN_ALU,
  output logic             EN_ADDR,
  output logic             CS,
  output logic             WE,
  output logic             OE
);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [4:0]       rn_q, rn_d;
  logic [4:0]       rt_q, rt_d;
  logic [63:0]      imm_q, imm_d;
  logic [LEN_W-1:0] eff_len;
  logic             last;
  ctrl_word_t       cw;

  always_comb begin
    if (req_len == '0)                      eff_len = LEN_W'(1);
    else if (req_len > LEN_W'(MAX_LEN))     eff_len = LEN_W'(MAX_LEN);
    else                                    eff_len = req_len;
  end

  assign last = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rn_d    = rn_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = req_store ? S_ST : S_LD_RD;
        idx_d   = '0;
        len_d   = eff_len;
        rn_d    = req_rn;
        rt_d    = req_rt;
        imm_d   = req_imm;
      end
      S_ST: begin
        idx_d = idx_q + LEN_W'(1);
        if (last) state_d = S_FIN;
      end
      S_LD_RD: state_d = S_LD_WB;
      S_LD_WB: begin
        idx_d   = idx_q + LEN_W'(1);
        state_d = last ? S_FIN : S_LD_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      rn_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rn_q    <= rn_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
    end
  end

  mem_ctrl_word_gen #(.LEN_W(LEN_W), .FS_SEL(FS_ADD)) u_cw (
    .state_i (state_q),
    .rn_i    (rn_q),
    .rt_i    (rt_q),
    .imm_i   (imm_q),
    .idx_i   (idx_q),
    .cw_o    (cw)
  );

  // Ready is held low while reset is asserted so no request slips in at release.
  assign req_ready = rst && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  assign SA      = cw.sa;
  assign SB      = cw.sb;
  assign DA      = cw.da;
  assign FS      = cw.fs;
  assign K       = cw.k;
  assign K_SEL   = cw.k_sel;
  assign C0      = cw.c0;
  assign W       = cw.w;
  assign EN_B    = cw.en_b;
  assign EN_ALU  = cw.en_alu;
  assign EN_ADDR = cw.en_addr;
  assign CS      = cw.cs;
  assign WE      = cw.we;
  assign OE      = cw.oe;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: accepted requests push a per-cycle control transcript and a
// reference register/memory image; a negedge monitor models the datapath and compares.
module tb_mem_access_ctrl;

  localparam int         MAX_LEN = 4;
  localparam int         LEN_W   = 3;
  localparam logic [4:0] FSA     = 5'b01000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_store;
  logic [4:0]       req_rn, req_rt;
  logic [63:0]      req_imm;
  logic [LEN_W-1:0] req_len;
  logic             busy, done;
  logic [4:0]       SA, SB, DA, FS;
  logic [63:0]      K;
  logic             K_SEL, C0, W, EN_B, EN_ALU, EN_ADDR, CS, WE, OE;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FS_ADD(FSA)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_rn(req_rn), .req_rt(req_rt), .req_imm(req_imm),
    .req_len(req_len), .busy(busy), .done(done), .SA(SA), .SB(SB), .DA(DA),
    .FS(FS), .K(K), .K_SEL(K_SEL), .C0(C0), .W(W), .EN_B(EN_B), .EN_ALU(EN_ALU),
    .EN_ADDR(EN_ADDR), .CS(CS), .WE(WE), .OE(OE)
  );

  typedef struct packed {
    logic ready, busy, done;
    logic [4:0] sa, sb, da, fs;
    logic [63:0] k;
    logic k_sel, c0, w, en_b, en_alu, en_addr, cs, we, oe;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   chk;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] X  [32];
  logic [63:0] Xr [32];
  logic [63:0] mem  [logic [63:0]];
  logic [63:0] memr [logic [63:0]];
  int checks = 0, failures = 0;

  function automatic logic [63:0] rdm(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] rdmr(input logic [63:0] a);
    return memr.exists(a) ? memr[a] : 64'h0;
  endfunction

  task automatic setreg(input int r, input logic [63:0] v);
    X[r] = v; Xr[r] = v;
  endtask

  task automatic setmem(input logic [63:0] a, input logic [63:0] v);
    mem[a] = v; memr[a] = v;
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  task automatic compare_data(input string name);
    int bad = 0;
    for (int r = 0; r < 32; r++) if (X[r] !== Xr[r]) bad++;
    foreach (memr[a]) if (rdm(a) !== memr[a]) bad++;
    foreach (mem[a])  if (rdmr(a) !== mem[a]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s data image differs in %0d locations (got != expected)", name, bad);
    end
  endtask

  // Expected cycle-by-cycle transcript from the access rules, plus reference effects.
  function automatic void push_txn(input bit st, input logic [4:0] rn, input logic [4:0] rt,
                                   input logic [63:0] imm, input logic [LEN_W-1:0] len,
                                   input int nref);
    int L;
    exp_t it;
    logic [4:0] r;
    logic [63:0] a;
    L = int'(len);
    if (L == 0) L = 1;
    if (L > MAX_LEN) L = MAX_LEN;
    for (int i = 0; i < L; i++) begin
      r = 5'(int'(rt) + i);
      it.o = '0; it.chk = 1'b0;
      it.o.busy = 1'b1; it.o.sa = rn; it.o.fs = FSA; it.o.k = imm + 64'(8 * i);
      it.o.k_sel = 1'b1; it.o.en_addr = 1'b1; it.o.cs = 1'b1;
      if (st) begin
        it.o.sb = r; it.o.en_b = 1'b1; it.o.we = 1'b1;
        exp_q.push_back(it);
      end else begin
        it.o.da = r; it.o.oe = 1'b1;
        exp_q.push_back(it);
        it.o.w = 1'b1;
        exp_q.push_back(it);
      end
    end
    it.o = '0; it.o.busy = 1'b1; it.o.done = 1'b1; it.chk = 1'b1;
    exp_q.push_back(it);
    for (int i = 0; i < L && i < nref; i++) begin
      r = 5'(int'(rt) + i);
      a = Xr[rn] + imm + 64'(8 * i);
      if (st) memr[a] = Xr[r];
      else    Xr[r]   = rdmr(a);
    end
  endfunction

  task automatic monitor_loop();
    obs_t got, idle;
    exp_t it;
    idle = '0; idle.ready = 1'b1;
    forever begin
      @(negedge clk);
      got = {req_ready, busy, done, SA, SB, DA, FS, K, K_SEL, C0, W, EN_B, EN_ALU, EN_ADDR, CS, WE, OE};
      checks++;
      if ((EN_B && OE) || (WE && OE) || EN_ALU) begin
        failures++;
        $display("FAIL bus_contention t=%0t got EN_B=%b WE=%b OE=%b EN_ALU=%b expected no overlap", $time, EN_B, WE, OE, EN_ALU);
      end
      if (!rst) begin
        got.ready = 1'b0;
        check_val("reset_outputs", 64'(got != '0), 64'd0);
      end else begin
        if (exp_q.size() > 0) it = exp_q.pop_front();
        else begin it.o = idle; it.chk = 1'b0; end
        if (CS && WE && EN_B) mem[X[SA] + K] = X[SB];
        if (CS && OE && W)    X[DA] = rdm(X[SA] + K);
        checks++;
        if (got !== it.o) begin
          failures++;
          $display("FAIL ctl_word t=%0t got=%h expected=%h", $time, got, it.o);
        end
        if (it.chk) compare_data("txn_data");
      end
    end
  endtask

  task automatic issue(input bit st, input logic [4:0] rn, input logic [4:0] rt,
                       input logic [63:0] imm, input logic [LEN_W-1:0] len, input int nref);
    bit rdy, ok;
    ok = 1'b0;
    req_valid = 1'b1; req_store = st; req_rn = rn; req_rt = rt; req_imm = imm; req_len = len;
    for (int n = 0; n < 100; n++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    #1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout got=no_accept expected=accept");
    end else push_txn(st, rn, rt, imm, len, nref);
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin lat = c; break; end
    end
    check_val(name, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    logic [63:0] keep11;
    int off;
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_rn = '0; req_rt = '0;
    req_imm = '0; req_len = '0;
    for (int r = 0; r < 32; r++) setreg(r, 64'h0);
    fork monitor_loop(); join_none
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single store
    setreg(2, 64'h100); setreg(5, 64'hDEAD);
    issue(1'b1, 5'd2, 5'd5, 64'd16, 3'd1, 99); req_valid = 1'b0;
    wait_done("store_latency", 2);
    check_val("store_mem", rdm(64'h110), 64'hDEAD);

    // Single load, negative offset
    @(negedge clk);
    setmem(64'hF8, 64'h1234);
    issue(1'b0, 5'd2, 5'd7, -64'sd8, 3'd1, 99); req_valid = 1'b0;
    wait_done("load_latency", 3);
    check_val("load_reg", X[7], 64'h1234);

    // Burst load wrapping rt 30 -> 31 -> 0
    @(negedge clk);
    setmem(64'h100, 64'hA0); setmem(64'h108, 64'hA1); setmem(64'h110, 64'hA2);
    issue(1'b0, 5'd2, 5'd30, 64'd0, 3'd3, 99); req_valid = 1'b0;
    wait_done("burst_latency", 7);
    check_val("burst_x30", X[30], 64'hA0);
    check_val("burst_x31", X[31], 64'hA1);
    check_val("burst_x0",  X[0],  64'hA2);

    // Reset during the second LD_RD of a 4-word load
    @(negedge clk);
    setmem(64'h100, 64'hB0); setmem(64'h108, 64'hB1);
    keep11 = X[11];
    issue(1'b0, 5'd2, 5'd10, 64'd0, 3'd4, 1); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    #1 check_val("reset_immediate",
                 64'({busy, done, SA, SB, DA, FS, K, K_SEL, C0, W, EN_B, EN_ALU, EN_ADDR, CS, WE, OE} != '0), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 check_val("ready_after_reset", 64'(req_ready), 64'd1);
    check_val("reset_first_written", X[10], 64'hB0);
    check_val("reset_second_untouched", X[11], keep11);
    compare_data("reset_image");

    // Back-to-back with valid held high
    @(negedge clk);
    issue(1'b1, 5'd2, 5'd10, 64'd32, 3'd2, 99);
    issue(1'b0, 5'd2, 5'd20, 64'd32, 3'd2, 99);
    req_valid = 1'b0;
    wait_done("b2b_second_latency", 5);

    // Length edges: 0 -> one word, 7 -> clamped to MAX_LEN
    @(negedge clk);
    issue(1'b1, 5'd2, 5'd3, 64'd64, 3'd0, 99); req_valid = 1'b0;
    wait_done("len0_latency", 2);
    @(negedge clk);
    issue(1'b0, 5'd2, 5'd12, 64'd64, 3'd7, 99); req_valid = 1'b0;
    wait_done("len7_latency", 2 * MAX_LEN + 1);

    // Randomized traffic
    for (int r = 0; r < 32; r++) setreg(r, 64'h1000 + 64'($urandom_range(0, 31)) * 8);
    for (int i = 0; i < 16; i++) setmem(64'h1000 + 64'(i) * 8, 64'($urandom));
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      off = int'($urandom_range(0, 32)) * 8 - 128;
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            64'(off), LEN_W'($urandom_range(0, 7)), 99);
      if ($urandom_range(0, 2) != 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_valid = 1'b0;

    for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_val("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    compare_data("final_image");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
